// File: rtl/shift_input_conditioner.sv
// ---------------------------------------------------------------------------
// shift_input_conditioner
//   Front end for the 4-bit serial shift register. It synchronises and
//   debounces a raw pushbutton (shift request) and a raw slide switch (serial
//   data). For every accepted press it emits a one-clk shift_pulse and
//   presents the debounced switch level on data_bit.
//
// Parameters
//   DEBOUNCE_CYCLES  stable clk cycles needed to accept a level change (>= 1)
//   KEY_ACTIVE_LOW   1: key_raw == 0 means pressed; 0: key_raw == 1 means pressed
//   CNT_W            debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk          in   system clock, single domain
//   reset        in   synchronous, active-high reset
//   key_raw      in   raw asynchronous pushbutton
//   sw_raw       in   raw asynchronous slide switch
//   shift_pulse  out  one-clk strobe per accepted press
//   data_bit     out  debounced switch value captured at the press
//   key_level    out  debounced key state, 1 = pressed
//   press_count  out  accepted presses, wraps 255 -> 0
// ---------------------------------------------------------------------------
module shift_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          KEY_ACTIVE_LOW  = 1'b1,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_raw,
    input  logic       sw_raw,
    output logic       shift_pulse,
    output logic       data_bit,
    output logic       key_level,
    output logic [7:0] press_count
);

    localparam logic             KEY_RELEASED_LVL = KEY_ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] CNT_MAX          = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE          = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } key_state_e;

    logic [1:0]       key_sync_q, key_sync_d;
    logic [1:0]       sw_sync_q, sw_sync_d;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] key_cnt_q, key_cnt_d;
    logic [CNT_W-1:0] sw_cnt_q, sw_cnt_d;
    logic             sw_stable_q, sw_stable_d;
    logic             shift_pulse_q, shift_pulse_d;
    logic             data_bit_q, data_bit_d;
    logic             key_level_q, key_level_d;
    logic [7:0]       press_count_q, press_count_d;

    logic key_s;
    logic sw_s;

    // Second synchroniser stage, key normalised so that 1 means pressed.
    assign key_s = key_sync_q[1] ^ KEY_RELEASED_LVL;
    assign sw_s  = sw_sync_q[1];

    always_comb begin
        key_sync_d    = {key_sync_q[0], key_raw};
        sw_sync_d     = {sw_sync_q[0], sw_raw};

        state_d       = state_q;
        key_cnt_d     = key_cnt_q;
        shift_pulse_d = 1'b0;
        data_bit_d    = data_bit_q;
        press_count_d = press_count_q;

        case (state_q)
            RELEASED: begin
                if (key_s) begin
                    state_d   = PRESS_CHK;
                    key_cnt_d = CNT_ONE;
                end
            end
            PRESS_CHK: begin
                if (!key_s) begin
                    state_d   = RELEASED;
                    key_cnt_d = '0;
                end else if (key_cnt_q == CNT_MAX) begin
                    state_d       = PRESSED;
                    key_cnt_d     = '0;
                    shift_pulse_d = 1'b1;
                    // Pre-edge sw_stable: a switch commit on this same edge is not seen.
                    data_bit_d    = sw_stable_q;
                    press_count_d = press_count_q + 8'd1;
                end else begin
                    key_cnt_d = key_cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    state_d   = RELEASE_CHK;
                    key_cnt_d = CNT_ONE;
                end
            end
            RELEASE_CHK: begin
                if (key_s) begin
                    state_d   = PRESSED;
                    key_cnt_d = '0;
                end else if (key_cnt_q == CNT_MAX) begin
                    state_d   = RELEASED;
                    key_cnt_d = '0;
                end else begin
                    key_cnt_d = key_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d   = RELEASED;
                key_cnt_d = '0;
            end
        endcase

        // Registered from the next state so key_level tracks state_q exactly.
        key_level_d = (state_d == PRESSED) || (state_d == RELEASE_CHK);

        sw_stable_d = sw_stable_q;
        sw_cnt_d    = sw_cnt_q;
        if (sw_s == sw_stable_q) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == CNT_MAX) begin
            sw_stable_d = sw_s;
            sw_cnt_d    = '0;
        end else begin
            sw_cnt_d = sw_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync_q    <= {2{KEY_RELEASED_LVL}};
            sw_sync_q     <= '0;
            state_q       <= RELEASED;
            key_cnt_q     <= '0;
            sw_cnt_q      <= '0;
            sw_stable_q   <= 1'b0;
            shift_pulse_q <= 1'b0;
            data_bit_q    <= 1'b0;
            key_level_q   <= 1'b0;
            press_count_q <= '0;
        end else begin
            key_sync_q    <= key_sync_d;
            sw_sync_q     <= sw_sync_d;
            state_q       <= state_d;
            key_cnt_q     <= key_cnt_d;
            sw_cnt_q      <= sw_cnt_d;
            sw_stable_q   <= sw_stable_d;
            shift_pulse_q <= shift_pulse_d;
            data_bit_q    <= data_bit_d;
            key_level_q   <= key_level_d;
            press_count_q <= press_count_d;
        end
    end

    assign shift_pulse = shift_pulse_q;
    assign data_bit    = data_bit_q;
    assign key_level   = key_level_q;
    assign press_count = press_count_q;

endmodule
